// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - Shared types and constants for the memory bus arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - One-hot pick: lowest index (fixed) or first at/after ptr (round-robin)
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk the N candidates in priority order; the first active one wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (mode == ARB_RR) begin
                idx = PW'((int'(ptr) + k) % N);
            end else begin
                idx = PW'(k);
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - Memory bus arbiter with fixed/round-robin pick and bus locking
// Optional forced lock release: define MEM_ARB_LOCK_TIMEOUT_EN
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_mode,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      lock_timeout,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data_out,
    output logic                      mem_write_en,
    output logic                      mem_read_en,
    input  logic [DATA_W-1:0]         mem_data_in
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX < 1) begin : g_param_check
        $error("mem_bus_arbiter: parameter out of range");
    end

    arb_state_t          state;
    arb_state_t          state_next;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       ptr;
    logic [NUM_REQ-1:0]  owner_mask;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [NUM_REQ-1:0]  lock_eff;
    logic                accept;
    logic [IW-1:0]       acc_idx;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_lock;
    logic                lock_release;
    logic                timeout_hit;
    logic [IW-1:0]       rd_idx;

    rr_picker #(
        .N  (NUM_REQ),
        .PW (IW)
    ) u_rr_picker (
        .req  (req),
        .ptr  (ptr),
        .mode (arb_mode),
        .gnt  (pick_gnt)
    );

    assign owner_mask = ONE_HOT0 << owner;
    assign accept     = |gnt;
    assign acc_lock   = accept && lock_eff[acc_idx];

    // While locked, only the owner's transfer or its dropping req_lock ends the hold.
    assign lock_release = accept ? !lock_eff[acc_idx] : !req_lock[owner];

    always_comb begin
        acc_idx   = '0;
        acc_addr  = '0;
        acc_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                acc_idx   = IW'(i);
                acc_addr  = req_addr[i*ADDR_W +: ADDR_W];
                acc_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef MEM_ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0]      lock_cnt;
    logic [NUM_REQ-1:0] lock_ign;
    logic               lock_timeout_q;

    // A timed-out owner may not relock until it lets go of req_lock once.
    assign lock_eff    = req_lock & ~lock_ign;
    assign timeout_hit = (state == LOCKED) && !lock_release &&
                         (lock_cnt == CW'(LOCK_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_cnt       <= '0;
            lock_ign       <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            if (state == LOCKED && state_next == LOCKED) begin
                lock_cnt <= lock_cnt + CW'(1);
            end else begin
                lock_cnt <= '0;
            end
            lock_ign       <= (lock_ign & req_lock) | (timeout_hit ? owner_mask : '0);
            lock_timeout_q <= timeout_hit;
        end
    end

    assign lock_timeout = lock_timeout_q;
`else
    assign lock_eff     = req_lock;
    assign timeout_hit  = 1'b0;
    assign lock_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state != LOCKED && acc_lock) begin
                owner <= acc_idx;
            end
            if (accept && arb_mode == ARB_RR) begin
                ptr <= (acc_idx == IW'(NUM_REQ - 1)) ? '0 : acc_idx + IW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, OPEN: begin
                if (accept) begin
                    state_next = acc_lock ? LOCKED : OPEN;
                end else begin
                    state_next = IDLE;
                end
            end
            LOCKED: begin
                if (lock_release) begin
                    state_next = accept ? OPEN : IDLE;
                end else if (timeout_hit) begin
                    state_next = OPEN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (!rst) begin
            gnt = '0;
        end else if (state == LOCKED) begin
            gnt = req & owner_mask;
        end else begin
            gnt = pick_gnt;
        end
    end

    // Memory-side strobes are a one-cycle registered copy of the accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr     <= '0;
            mem_data_out <= '0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            rd_idx       <= '0;
            rvalid       <= '0;
        end else begin
            if (accept) begin
                mem_addr     <= acc_addr;
                mem_data_out <= acc_wdata;
                mem_write_en <= req_we[acc_idx];
                mem_read_en  <= !req_we[acc_idx];
                rd_idx       <= acc_idx;
            end else begin
                mem_write_en <= 1'b0;
                mem_read_en  <= 1'b0;
            end
            rvalid <= mem_read_en ? (ONE_HOT0 << rd_idx) : '0;
        end
    end

    assign rdata = mem_data_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - Self-checking bench for mem_bus_arbiter against a rule-level model
module tb_mem_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LM = 4;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int S_IDLE = 0;
    localparam int S_OPEN = 1;
    localparam int S_LOCK = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            arb_mode = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            lock_timeout;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_out;
    logic            mem_write_en;
    logic            mem_read_en;
    logic [DW-1:0]   mem_data_in = '0;

    int checks   = 0;
    int failures = 0;

    int           m_state;
    int           m_owner;
    int           m_ptr;
    int           m_locked_cycles;
    bit [N-1:0]   m_ign;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_we;
    logic          e_re;
    logic          e_to;
    logic [N-1:0]  e_rvalid;
    int            e_rd;

    int            last_g;
    logic [N-1:0]  gnt_seen;

    mem_bus_arbiter #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .LOCK_MAX (LM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arb_mode     (arb_mode),
        .req          (req),
        .req_we       (req_we),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .lock_timeout (lock_timeout),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_data_in  (mem_data_in)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic int model_pick();
        if (m_state == S_LOCK) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = arb_mode ? (m_ptr + k) % N : k;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_owner = 0;
        m_ptr = 0;
        m_locked_cycles = 0;
        m_ign = '0;
        e_addr = '0;
        e_wdata = '0;
        e_we = 1'b0;
        e_re = 1'b0;
        e_to = 1'b0;
        e_rvalid = '0;
        e_rd = 0;
    endtask

    task automatic model_update(input int g);
        bit lk;
        e_rvalid = e_re ? onehot(e_rd) : '0;
        e_to = 1'b0;
        if (g >= 0) begin
            e_addr  = req_addr[g*AW +: AW];
            e_wdata = req_wdata[g*DW +: DW];
            e_we    = req_we[g];
            e_re    = !req_we[g];
            e_rd    = g;
        end else begin
            e_we = 1'b0;
            e_re = 1'b0;
        end
        lk = (g >= 0) && req_lock[g] && !m_ign[g];
        m_ign = m_ign & req_lock;
        if (m_state == S_LOCK) begin
            if (g >= 0 && !lk) begin
                m_state = S_OPEN;
            end else if (g < 0 && !req_lock[m_owner]) begin
                m_state = S_IDLE;
            end else if (TO_EN && m_locked_cycles + 1 == LM) begin
                m_state = S_OPEN;
                e_to = 1'b1;
                m_ign[m_owner] = 1'b1;
            end else begin
                m_locked_cycles++;
            end
        end else if (g >= 0) begin
            if (lk) begin
                m_state = S_LOCK;
                m_owner = g;
                m_locked_cycles = 0;
            end else begin
                m_state = S_OPEN;
            end
        end else begin
            m_state = S_IDLE;
        end
        if (g >= 0 && arb_mode) m_ptr = (g + 1) % N;
    endtask

    task automatic step();
        int g;
        @(negedge clk);
        g = model_pick();
        check_eq("gnt", gnt, onehot(g));
        check_eq("rdata", rdata, mem_data_in);
        gnt_seen = gnt;
        last_g = g;
        @(posedge clk);
        #1;
        model_update(g);
        check_eq("mem_write_en", mem_write_en, e_we);
        check_eq("mem_read_en", mem_read_en, e_re);
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_data_out", mem_data_out, e_wdata);
        check_eq("rvalid", rvalid, e_rvalid);
        check_eq("lock_timeout", lock_timeout, e_to);
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b0;
        req = '1;
        #1;
        check_eq("rst_gnt", gnt, '0);
        check_eq("rst_mem_write_en", mem_write_en, 0);
        check_eq("rst_mem_read_en", mem_read_en, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_data_out", mem_data_out, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_lock_timeout", lock_timeout, 0);
        req = '0;
        req_we = '0;
        req_lock = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic new_txn(input int i);
        req[i] = 1'b1;
        req_we[i] = 1'($urandom % 2);
        req_addr[i*AW +: AW] = AW'($urandom);
        req_wdata[i*DW +: DW] = DW'($urandom);
        req_lock[i] = ($urandom % 6 == 0);
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (req[i] && last_g == i) begin
                if ($urandom % 3 == 0) req[i] = 1'b0;
                else new_txn(i);
            end else if (!req[i]) begin
                if ($urandom % 3 == 0) new_txn(i);
                else req_lock[i] = ($urandom % 4 == 0);
            end
        end
        mem_data_in = DW'($urandom);
        if ($urandom % 40 == 0) arb_mode = ~arb_mode;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = DW'(a) ^ 8'h3C;
    endtask

    initial begin
        logic [N-1:0] rr_seq [8];
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        last_g = -1;
        model_reset();
        apply_reset();

        // Fixed priority starves the higher index.
        arb_mode = 1'b0;
        set_req(0, 1'b1, 16'h0100);
        set_req(1, 1'b1, 16'h0101);
        for (int c = 0; c < 6; c++) begin
            step();
            check_eq("fixed_starve", gnt_seen, 4'b0001);
        end
        req = '0;
        step();

        apply_reset();
        arb_mode = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(16'h1000 + i));
        for (int c = 0; c < 8; c++) begin
            step();
            check_eq("rr_sequence", gnt_seen, rr_seq[c]);
        end
        req = '0;
        step();

        // Single read by requester 1.
        set_req(1, 1'b0, 16'h2002);
        step();
        check_eq("read_gnt", gnt_seen, 4'b0010);
        req = '0;
        check_eq("read_strobe", mem_read_en, 1'b1);
        check_eq("read_addr", mem_addr, 16'h2002);
        step();
        mem_data_in = 8'h5A;
        #1;
        check_eq("read_rvalid", rvalid, 4'b0010);
        check_eq("read_rdata", rdata, 8'h5A);
        step();

        // Requester 0 holds the lock for three transfers, then an unlocked one.
        apply_reset();
        arb_mode = 1'b1;
        set_req(0, 1'b1, 16'h3000);
        set_req(1, 1'b1, 16'h3001);
        req_lock = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("lock_hold_gnt", gnt_seen, 4'b0001);
        end
        req_lock = '0;
        step();
        check_eq("lock_unlocked_gnt", gnt_seen, 4'b0001);
        step();
        check_eq("lock_after_gnt", gnt_seen, 4'b0010);
        req = '0;
        step();

        // Lock held indefinitely; forced release only with the timeout build.
        apply_reset();
        arb_mode = 1'b1;
        set_req(0, 1'b1, 16'h4000);
        set_req(1, 1'b1, 16'h4001);
        req_lock = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            step();
            check_eq("timeout_gnt", gnt_seen, (TO_EN && c == 5) ? 4'b0010 : 4'b0001);
            check_eq("timeout_pulse", lock_timeout, TO_EN && c == 4);
        end
        req = '0;
        req_lock = '0;
        step();

        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            step();
            drive_random();
        end
        req = '0;
        req_lock = '0;
        step();

        // Reset while a read is in flight.
        set_req(2, 1'b0, 16'h5002);
        step();
        req = '0;
        check_eq("inflight_read_en", mem_read_en, 1'b1);
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("no_rvalid_after_rst", rvalid, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of bus requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter DATA_W, default 8, data width.
REQ-004 SHALL have parameter LOCK_MAX, default 64, maximum locked-ownership cycles (used only under REQ-027).
REQ-005 SHALL have ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- arb_mode  in  1  0 = fixed priority, 1 = round-robin.
- req  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  per-requester write (1) / read (0).
- req_lock  in  NUM_REQ  per-requester bus-lock request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot accept, combinational.
- rvalid  out  NUM_REQ  one-hot read-data-valid.
- rdata  out  DATA_W  read data, broadcast to all requesters.
- lock_timeout  out  1  one-cycle forced-release pulse.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_data_out  out  DATA_W  memory write data, registered.
- mem_write_en  out  1  memory write strobe, registered.
- mem_read_en  out  1  memory read strobe, registered.
- mem_data_in  in  DATA_W  memory read data, valid the cycle after mem_read_en.

Function
REQ-006 SHALL assert at most one gnt bit per cycle; gnt[i] implies req[i].
REQ-007 SHALL accept a transfer when gnt[i] is high at a rising edge; requester i SHALL hold req, req_we, req_addr and req_wdata stable until then.
REQ-008 SHALL drive mem_addr, mem_data_out, mem_write_en and mem_read_en in the cycle after acceptance, from the accepted requester's signals; with no acceptance both strobes SHALL be 0 and addr/data SHALL hold.
REQ-009 SHALL sustain one accepted transfer per cycle (back-to-back, no bubbles).
REQ-010 SHALL, in the cycle after a mem_read_en cycle, assert rvalid for the requester that issued the read, with rdata = mem_data_in.
REQ-011 SHALL drive rvalid as 0 in every cycle not covered by REQ-010; rdata SHALL equal mem_data_in at all times.
REQ-012 arb_mode=0: SHALL grant the lowest-index active req.
REQ-013 arb_mode=1: SHALL grant the first active req at or after index ptr, wrapping from NUM_REQ-1 to 0; ptr SHALL become (granted index + 1) mod NUM_REQ on each acceptance.
REQ-014 SHALL keep ptr unchanged in mode 0 and when no acceptance occurs; a mode change SHALL take effect on the next cycle without resetting ptr.
REQ-015 SHALL implement states IDLE (no owner), OPEN (last cycle accepted an unlocked transfer), LOCKED (owner held).
REQ-016 IDLE/OPEN -> LOCKED when the accepted transfer has req_lock high; owner = that requester.
REQ-017 In LOCKED, SHALL grant only the owner, regardless of arb_mode; other requests SHALL wait.
REQ-018 LOCKED -> OPEN on an accepted owner transfer with req_lock low; LOCKED -> IDLE when the owner drops req_lock without a transfer.
REQ-019 OPEN -> IDLE on a cycle with no acceptance; IDLE -> OPEN on an unlocked acceptance.
REQ-020 With req all zero, gnt SHALL be 0 and no strobe SHALL be issued.
REQ-021 SHALL never assert mem_write_en and mem_read_en together.

Reset
REQ-022 On rst low, SHALL asynchronously clear mem_addr, mem_data_out, mem_write_en, mem_read_en, rvalid and lock_timeout to 0.
REQ-023 On rst low, SHALL set state IDLE, ptr 0, lock owner none, lock counter 0.
REQ-024 SHALL discard any read in flight at reset; no rvalid SHALL follow reset release for it.
REQ-025 gnt SHALL be 0 while rst is low.

Configuration
REQ-026 Macro MEM_ARB_LOCK_TIMEOUT_EN SHALL select lock-timeout logic.
REQ-027 With MEM_ARB_LOCK_TIMEOUT_EN defined, SHALL count cycles in LOCKED; on reaching LOCK_MAX, SHALL force LOCKED -> OPEN, pulse lock_timeout for one cycle, and ignore req_lock of that owner until its req_lock deasserts.
REQ-028 Without MEM_ARB_LOCK_TIMEOUT_EN, SHALL tie lock_timeout to 0 and hold lock indefinitely; no counter SHALL be synthesised.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum (IDLE, OPEN, LOCKED) and the arb-mode constants.
REQ-030 Sub-module rr_picker SHALL implement the one-hot rotating-priority pick from req, ptr and mode.

Verification
REQ-031 NUM_REQ=2, mode 0, req=2'b11 continuously -> gnt=2'b01 every cycle; requester 1 starves.
REQ-032 NUM_REQ=4, mode 1, req=4'b1111 for 8 cycles -> gnt sequence 1,2,4,8,1,2,4,8.
REQ-033 Read by requester 1 at addr 16'h2002, memory returns 8'h5A -> mem_read_en one cycle after gnt; rvalid=2'b10, rdata=8'h5A one cycle later.
REQ-034 Requester 0 locks for 3 transfers while req[1] is high -> gnt[1] low throughout; gnt[1] in the cycle after the unlocked transfer.
REQ-035 MEM_ARB_LOCK_TIMEOUT_EN, LOCK_MAX=4, lock held -> lock_timeout pulses after 4 LOCKED cycles and requester 1 is granted next.
REQ-036 rst low in the cycle after mem_read_en -> all outputs 0 and no rvalid after release.
